vga_scene_renderer: RTL and testbench
=====================================

# vga_scene_renderer

Parametrised VGA scene renderer, successor to the fixed-geometry frogger display block. Generates sync and scan counters for any timing set. Draws a frog sprite, border and `NUM_CROC` crocodile lanes from packed position buses, with a registered 8-bit RGB output. Latches positions once per frame so there is no tearing, and reports a per-frame frog/croc collision flag to the game controller.

## Interface
- `HTOTAL`, 800: pixels per line.
- `VTOTAL`, 521: lines per frame.
- `HPULSE`, 96: hsync width in pixels.
- `VPULSE`, 2: vsync width in lines.
- `HBP`, 144: first active column.
- `HFP`, 784: first column after active.
- `VBP`, 31: first active line.
- `VFP`, 511: first line after active.
- `NUM_CROC`, 3: croc lane count (1..8).
- `FROG_SIZE`, 32: frog side in pixels.
- `CROC_W`, 16: croc width in pixels.
- `CROC_LEN`, 92: croc height in lines.
- `CROC_YOFF`, 8: vertical offset added to each croc Y.
- `dclk`  in  1  pixel clock.
- `rst`  in  1  synchronous active-high reset; one clock; reset is synchronous and active-high.
- `frog_x`  in  10  frog left column, in counter coordinates.
- `frog_y`  in  10  frog top line.
- `croc_y`  in  9*NUM_CROC  croc i top = bits [9i+8:9i].
- `croc_x`  in  10*NUM_CROC  croc i left column = bits [10i+9:10i].
- `vga_h_sync`, `vga_v_sync`  out  1  registered syncs, active-high.
- `vga_R`  out  3  red.
- `vga_G`  out  3  green.
- `vga_B`  out  2  blue.
- `in_frog`, `in_croc`  out  1  registered per-pixel region flags.
- `frame_done`  out  1  one-cycle pulse per frame.
- `collide`  out  1  frog/croc overlap seen in the last completed frame.

## Operation
- Counters: `hx` runs 0..HTOTAL-1. On wrap, `vy` advances over 0..VTOTAL-1 and wraps to 0.
- Shadow registers hold all position inputs. They load on the edge where the counters move from (HTOTAL-1, VTOTAL-1) to (0,0). Input changes mid-frame are invisible until the next frame.
- All region compares use 11-bit sums, so a sprite near 1023 never wraps to column 0.
- Frog region: `frog_x` <= hx < `frog_x` + FROG_SIZE, and `frog_y` <= vy < `frog_y` + FROG_SIZE.
- Croc i region: `croc_x`i <= hx < `croc_x`i + CROC_W, and `croc_y`i + CROC_YOFF <= vy < `croc_y`i + CROC_YOFF + CROC_LEN.
- `in_croc` is the OR over all lanes.
- Active area: HBP <= hx < HFP and VBP <= vy < VFP.
- Colour priority:
  - outside active area: black 000/000/00;
  - border: 111/000/11;
  - croc: 111/000/00;
  - frog: 000/111/00;
  - otherwise white 111/111/11.
- Collision: the sticky bit `hit` sets when frog and croc regions coincide at an active pixel. At the frame-wrap edge, `collide` <= `hit` OR the current-pixel overlap, then `hit` clears.
- Reset clears counters, shadows, `hit`, and all outputs to 0: RGB black, syncs low, `collide` 0, `frame_done` 0.

## Timing
- Pipeline latency is one cycle. RGB, syncs, `in_frog` and `in_croc` for counter position (hx, vy) appear on the clock after (hx, vy) is presented.
- `vga_h_sync` = 1 when hx < HPULSE; `vga_v_sync` = 1 when vy < VPULSE; both delayed one cycle.
- `frame_done` is high for exactly the one cycle while the counters read (0,0). `collide` updates on the same edge and holds for the whole next frame.
- `rst` asserted mid-frame: the next cycle shows counters at (0,0) and all outputs at reset values, with no `frame_done` pulse. Normal scanning resumes the cycle after `rst` drops.
- Overlapping crocs OR together. A croc always has priority over the frog, but both flags assert.

## Configuration
- `SCENE_BORDER_EN` defined: border drawn as an 8-pixel band inside the active edges, i.e. hx in [HBP, HBP+8) or [HFP-8, HFP), or vy in [VBP, VBP+8) or [VFP-8, VFP).
- `SCENE_BORDER_EN` undefined: no border logic is compiled in, and those pixels fall through to croc/frog/white.

## Test plan
- Reset, then run defaults for 2 frames: `frame_done` pulses every 416800 cycles, hsync high 96 of 800 cycles, vsync high for 2 lines, RGB 0 wherever hx < 144.
- `frog_x`=300, `frog_y`=200, crocs off-screen: green for hx 300..331 at vy 200..231 (seen one cycle later), white at hx 332, and `collide`=0.
- `croc_x`0=300, `croc_y`0=190, frog as above: red over the overlap, `in_frog` and `in_croc` both 1 at (300,200), and `collide`=1 after the `frame_done` pulse.
- Change `frog_x` mid-frame at vy=250: rendering unchanged until vy=0 of the next frame, then the new position is drawn.
- `frog_x`=1010: no wrap, so hx 0..9 never flags frog.
- `rst` pulsed at vy=300: outputs zero the next cycle, the counters restart from (0,0), and the following `frame_done` arrives exactly 416800 cycles after `rst` deasserts.
- With `SCENE_BORDER_EN` undefined, pixel (144,31) is white rather than magenta.

Source files
------------

// File: rtl/vga_scene_renderer.sv
// Parametrised VGA scene renderer: scan counters, frame-latched sprite positions,
// frog/croc/border compositing with registered RGB, and a per-frame collision flag.
// Optional border band is compiled in when SCENE_BORDER_EN is defined.
module vga_scene_renderer #(
  parameter int HTOTAL    = 800,
  parameter int VTOTAL    = 521,
  parameter int HPULSE    = 96,
  parameter int VPULSE    = 2,
  parameter int HBP       = 144,
  parameter int HFP       = 784,
  parameter int VBP       = 31,
  parameter int VFP       = 511,
  parameter int NUM_CROC  = 3,
  parameter int FROG_SIZE = 32,
  parameter int CROC_W    = 16,
  parameter int CROC_LEN  = 92,
  parameter int CROC_YOFF = 8
) (
  input  logic                     dclk,
  input  logic                     rst,
  input  logic [9:0]               frog_x,
  input  logic [9:0]               frog_y,
  input  logic [9*NUM_CROC-1:0]    croc_y,
  input  logic [10*NUM_CROC-1:0]   croc_x,
  output logic                     vga_h_sync,
  output logic                     vga_v_sync,
  output logic [2:0]               vga_R,
  output logic [2:0]               vga_G,
  output logic [1:0]               vga_B,
  output logic                     in_frog,
  output logic                     in_croc,
  output logic                     frame_done,
  output logic                     collide
);

  localparam logic [9:0]  HLAST    = 10'(HTOTAL - 1);
  localparam logic [9:0]  VLAST    = 10'(VTOTAL - 1);
  localparam logic [10:0] HPULSE_W = 11'(HPULSE);
  localparam logic [10:0] VPULSE_W = 11'(VPULSE);
  localparam logic [10:0] HBP_W    = 11'(HBP);
  localparam logic [10:0] HFP_W    = 11'(HFP);
  localparam logic [10:0] VBP_W    = 11'(VBP);
  localparam logic [10:0] VFP_W    = 11'(VFP);
  localparam logic [10:0] FROG_W   = 11'(FROG_SIZE);
  localparam logic [10:0] CW_W     = 11'(CROC_W);
  localparam logic [10:0] LEN_W    = 11'(CROC_LEN);
  localparam logic [10:0] YOFF_W   = 11'(CROC_YOFF);

  logic [9:0]             hx, vy;
  logic [9:0]             frog_x_sh, frog_y_sh;
  logic [9*NUM_CROC-1:0]  croc_y_sh;
  logic [10*NUM_CROC-1:0] croc_x_sh;
  logic                   hit;

  logic [10:0] hx11, vy11, fx11, fy11;
  logic        frame_wrap;
  logic        in_frog_p0, in_croc_p0, active_p0, border_p0, overlap_p0;
  logic [7:0]  rgb_p0;

  // Stage p0: region decode for the pixel the counters present now
  assign hx11       = {1'b0, hx};
  assign vy11       = {1'b0, vy};
  assign fx11       = {1'b0, frog_x_sh};
  assign fy11       = {1'b0, frog_y_sh};
  assign frame_wrap = (hx == HLAST) && (vy == VLAST);

  assign active_p0  = (hx11 >= HBP_W) && (hx11 < HFP_W) && (vy11 >= VBP_W) && (vy11 < VFP_W);
  assign in_frog_p0 = (hx11 >= fx11) && (hx11 < fx11 + FROG_W) &&
                      (vy11 >= fy11) && (vy11 < fy11 + FROG_W);
  assign overlap_p0 = in_frog_p0 && in_croc_p0 && active_p0;

  always_comb begin
    logic [10:0] cx;
    logic [10:0] cy;
    cx         = '0;
    cy         = '0;
    in_croc_p0 = 1'b0;
    for (int i = 0; i < NUM_CROC; i++) begin
      cx = {1'b0, croc_x_sh[10*i +: 10]};
      cy = {2'b00, croc_y_sh[9*i +: 9]} + YOFF_W;
      if ((hx11 >= cx) && (hx11 < cx + CW_W) && (vy11 >= cy) && (vy11 < cy + LEN_W))
        in_croc_p0 = 1'b1;
    end
  end

`ifdef SCENE_BORDER_EN
  assign border_p0 = active_p0 &&
                     ((hx11 < HBP_W + 11'd8) || (hx11 >= HFP_W - 11'd8) ||
                      (vy11 < VBP_W + 11'd8) || (vy11 >= VFP_W - 11'd8));
`else
  assign border_p0 = 1'b0;
`endif

  always_comb begin
    rgb_p0 = 8'b111_111_11;
    if (!active_p0)      rgb_p0 = 8'b000_000_00;
    else if (border_p0)  rgb_p0 = 8'b111_000_11;
    else if (in_croc_p0) rgb_p0 = 8'b111_000_00;
    else if (in_frog_p0) rgb_p0 = 8'b000_111_00;
  end

  // Stage p1: counters, frame-boundary shadow load and registered outputs
  always_ff @(posedge dclk) begin
    if (rst) begin
      hx         <= '0;
      vy         <= '0;
      frog_x_sh  <= '0;
      frog_y_sh  <= '0;
      croc_x_sh  <= '0;
      croc_y_sh  <= '0;
      hit        <= 1'b0;
      collide    <= 1'b0;
      frame_done <= 1'b0;
      vga_h_sync <= 1'b0;
      vga_v_sync <= 1'b0;
      vga_R      <= '0;
      vga_G      <= '0;
      vga_B      <= '0;
      in_frog    <= 1'b0;
      in_croc    <= 1'b0;
    end else begin
      if (hx == HLAST) begin
        hx <= '0;
        vy <= (vy == VLAST) ? 10'd0 : vy + 10'd1;
      end else begin
        hx <= hx + 10'd1;
      end

      if (frame_wrap) begin
        // New positions take effect exactly at the first pixel of the next frame
        frog_x_sh <= frog_x;
        frog_y_sh <= frog_y;
        croc_x_sh <= croc_x;
        croc_y_sh <= croc_y;
        collide   <= hit || overlap_p0;
        hit       <= 1'b0;
      end else if (overlap_p0) begin
        hit <= 1'b1;
      end

      frame_done <= frame_wrap;
      vga_h_sync <= (hx11 < HPULSE_W);
      vga_v_sync <= (vy11 < VPULSE_W);
      vga_R      <= rgb_p0[7:5];
      vga_G      <= rgb_p0[4:2];
      vga_B      <= rgb_p0[1:0];
      in_frog    <= in_frog_p0;
      in_croc    <= in_croc_p0;
    end
  end

endmodule

// File: tb/tb_vga_scene_renderer.sv
// Bench for vga_scene_renderer on a reduced timing set; a per-pixel reference model
// derived from absolute cycle count checks every output on every clock.
module tb_vga_scene_renderer;

  localparam int H    = 64;
  localparam int V    = 40;
  localparam int HP   = 6;
  localparam int VP   = 2;
  localparam int HBP  = 10;
  localparam int HFP  = 58;
  localparam int VBP  = 4;
  localparam int VFP  = 36;
  localparam int NC   = 3;
  localparam int FS   = 8;
  localparam int CW   = 4;
  localparam int CL   = 10;
  localparam int YOFF = 2;
  localparam int FR   = H * V;

  logic              dclk = 1'b0;
  logic              rst;
  logic [9:0]        frog_x, frog_y;
  logic [9*NC-1:0]   croc_y;
  logic [10*NC-1:0]  croc_x;
  logic              vga_h_sync, vga_v_sync;
  logic [2:0]        vga_R, vga_G;
  logic [1:0]        vga_B;
  logic              in_frog, in_croc, frame_done, collide;

  vga_scene_renderer #(
    .HTOTAL(H), .VTOTAL(V), .HPULSE(HP), .VPULSE(VP), .HBP(HBP), .HFP(HFP),
    .VBP(VBP), .VFP(VFP), .NUM_CROC(NC), .FROG_SIZE(FS), .CROC_W(CW),
    .CROC_LEN(CL), .CROC_YOFF(YOFF)
  ) dut (
    .dclk(dclk), .rst(rst), .frog_x(frog_x), .frog_y(frog_y), .croc_y(croc_y),
    .croc_x(croc_x), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B), .in_frog(in_frog),
    .in_croc(in_croc), .frame_done(frame_done), .collide(collide)
  );

  always #5 dclk = ~dclk;

  typedef struct {
    int fx, fy, cx0, cy0, cx1, cy1;
    bit col;
  } vec_t;

  vec_t  tbl[8];
  int    errors = 0;
  int    checks = 0;
  longint t = 0;
  int    sfx, sfy;
  int    scx[NC];
  int    scy[NC];
  bit    hit_m, col_m;

  function automatic logic [11:0] model(int x, int y);
    bit f, c, act, brd;
    logic [7:0] rgb;
    f = (x >= sfx) && (x < sfx + FS) && (y >= sfy) && (y < sfy + FS);
    c = 1'b0;
    for (int i = 0; i < NC; i++)
      if ((x >= scx[i]) && (x < scx[i] + CW) && (y >= scy[i] + YOFF) && (y < scy[i] + YOFF + CL))
        c = 1'b1;
    act = (x >= HBP) && (x < HFP) && (y >= VBP) && (y < VFP);
`ifdef SCENE_BORDER_EN
    brd = (x < HBP + 8) || (x >= HFP - 8) || (y < VBP + 8) || (y >= VFP - 8);
`else
    brd = 1'b0;
`endif
    if (!act)    rgb = 8'h00;
    else if (brd) rgb = 8'b111_000_11;
    else if (c)  rgb = 8'b111_000_00;
    else if (f)  rgb = 8'b000_111_00;
    else         rgb = 8'hFF;
    return {x < HP, y < VP, f, c, rgb};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic set_inputs(input int fx, input int fy, input int cx0, input int cy0,
                            input int cx1, input int cy1);
    frog_x = 10'(fx);
    frog_y = 10'(fy);
    croc_x = {10'd1000, 10'(cx1), 10'(cx0)};
    croc_y = {9'd500, 9'(cy1), 9'(cy0)};
  endtask

  task automatic step();
    int p, x, y;
    logic [11:0] e;
    bit ov, last;
    p    = int'(t % FR);
    x    = p % H;
    y    = p / H;
    e    = model(x, y);
    ov   = e[9] && e[8] && (x >= HBP) && (x < HFP) && (y >= VBP) && (y < VFP);
    last = (p == FR - 1);
    if (ov) hit_m = 1'b1;
    if (last) begin
      col_m = hit_m;
      hit_m = 1'b0;
      sfx   = int'(frog_x);
      sfy   = int'(frog_y);
      for (int i = 0; i < NC; i++) begin
        scx[i] = int'(croc_x[10*i +: 10]);
        scy[i] = int'(croc_y[9*i +: 9]);
      end
    end
    @(posedge dclk);
    #1;
    t++;
    check("pix", {20'd0, vga_h_sync, vga_v_sync, in_frog, in_croc, vga_R, vga_G, vga_B}, {20'd0, e});
    check("frame_done", {31'd0, frame_done}, {31'd0, last});
    check("collide", {31'd0, collide}, {31'd0, col_m});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge dclk);
    #1;
    rst   = 1'b0;
    t     = 0;
    hit_m = 1'b0;
    col_m = 1'b0;
    sfx   = 0;
    sfy   = 0;
    for (int i = 0; i < NC; i++) begin
      scx[i] = 0;
      scy[i] = 0;
    end
    check("reset_outs", {18'd0, vga_h_sync, vga_v_sync, vga_R, vga_G, vga_B, in_frog, in_croc,
                         frame_done, collide}, 32'd0);
  endtask

  task automatic wait_frame(output int n, output int hs_cnt, output int vs_cnt);
    bit seen;
    n = 0; hs_cnt = 0; vs_cnt = 0; seen = 1'b0;
    while (!seen && n < FR + 8) begin
      step();
      n++;
      hs_cnt += int'(vga_h_sync);
      vs_cnt += int'(vga_v_sync);
      if (frame_done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame: no frame_done within %0d cycles", FR + 8);
    end
  endtask

  task automatic step_to_row(input int row);
    int k;
    k = 0;
    while (int'(t % FR) / H != row && k < FR + 8) begin
      step();
      k++;
    end
  endtask

  initial begin
    int n, hs, vs, k;
    tbl[0] = '{fx: 20,   fy: 10, cx0: 1000, cy0: 500, cx1: 1000, cy1: 500, col: 1'b0};
    tbl[1] = '{fx: 20,   fy: 10, cx0: 20,   cy0: 8,   cx1: 1000, cy1: 500, col: 1'b1};
    tbl[2] = '{fx: 20,   fy: 10, cx0: 28,   cy0: 8,   cx1: 1000, cy1: 500, col: 1'b0};
    tbl[3] = '{fx: 0,    fy: 10, cx0: 4,    cy0: 8,   cx1: 1000, cy1: 500, col: 1'b0};
    tbl[4] = '{fx: 1010, fy: 10, cx0: 1000, cy0: 500, cx1: 1000, cy1: 500, col: 1'b0};
    tbl[5] = '{fx: 40,   fy: 20, cx0: 30,   cy0: 15,  cx1: 44,   cy1: 12,  col: 1'b1};
    tbl[6] = '{fx: 30,   fy: 30, cx0: 30,   cy0: 24,  cx1: 1000, cy1: 500, col: 1'b1};
    tbl[7] = '{fx: 30,   fy: 36, cx0: 30,   cy0: 24,  cx1: 1000, cy1: 500, col: 1'b0};

    set_inputs(1000, 700, 1000, 500, 1000, 500);
    do_reset();

    // Two default frames: period and sync duty
    for (int f = 0; f < 2; f++) begin
      wait_frame(n, hs, vs);
      check("fd_period", n, FR);
      check("hs_count", hs, HP * V);
      check("vs_count", vs, VP * H);
    end

    // Table scenarios: inputs latch at one frame_done, collision reported at the next
    for (int i = 0; i < 8; i++) begin
      set_inputs(tbl[i].fx, tbl[i].fy, tbl[i].cx0, tbl[i].cy0, tbl[i].cx1, tbl[i].cy1);
      wait_frame(n, hs, vs);
      if (i > 0) check("collide_tbl", {31'd0, collide}, {31'd0, tbl[i-1].col});
    end
    wait_frame(n, hs, vs);
    check("collide_tbl", {31'd0, collide}, {31'd0, tbl[7].col});

    // Mid-frame position change stays invisible until the next frame
    set_inputs(20, 10, 1000, 500, 1000, 500);
    wait_frame(n, hs, vs);
    step_to_row(20);
    set_inputs(30, 22, 1000, 500, 1000, 500);
    wait_frame(n, hs, vs);
    wait_frame(n, hs, vs);

    // Reset mid-frame restarts scanning from (0,0)
    step_to_row(25);
    do_reset();
    wait_frame(n, hs, vs);
    check("rst_fd_delay", n, FR);

    // First active pixel: magenta with the border, white without
    set_inputs(1000, 700, 1000, 500, 1000, 500);
    wait_frame(n, hs, vs);
    k = 0;
    while (int'((t - 1) % FR) != VBP * H + HBP && k < FR + 8) begin
      step();
      k++;
    end
`ifdef SCENE_BORDER_EN
    check("corner_rgb", {24'd0, vga_R, vga_G, vga_B}, 32'hE3);
`else
    check("corner_rgb", {24'd0, vga_R, vga_G, vga_B}, 32'hFF);
`endif

    // Randomized scenes with random mid-frame updates
    for (int f = 0; f < 5; f++) begin
      set_inputs($urandom_range(0, 70), $urandom_range(0, 45), $urandom_range(0, 70),
                 $urandom_range(0, 40), $urandom_range(0, 70), $urandom_range(0, 40));
      croc_x[29:20] = 10'($urandom_range(0, 70));
      croc_y[26:18] = 9'($urandom_range(0, 40));
      step_to_row($urandom_range(1, V - 2));
      frog_x = 10'($urandom_range(0, 70));
      wait_frame(n, hs, vs);
    end
    wait_frame(n, hs, vs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
